// File: rtl/conv_pkg.sv
// conv_pkg: shared types and helpers for the conv stream engine and its writer.
// Optional feature macro used by the engine: CONV_PAD_EN (1-pixel zero border).
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam int DEF_K_H    = 3;
    localparam int DEF_K_W    = 3;
    localparam int DEF_DATA_W = 8;
    localparam int DEF_ACC_W  = 24;
    // Zero-extended pixel (DATA_W+1) times signed weight (DATA_W)
    localparam int DEF_PROD_W = 2 * DEF_DATA_W + 1;

    function automatic int prod_width(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // Output map dimension for an (already padded) input dimension
    function automatic int out_dim(input int in_dim, input int k, input logic s2);
        return s2 ? ((in_dim - k) / 2 + 1) : (in_dim - k + 1);
    endfunction

endpackage

// File: rtl/conv_mac.sv
// conv_mac: combinational K_H x K_W MAC of unsigned pixels and signed weights,
// plus bias and optional ReLU. The engine registers the result.
module conv_mac
    import conv_pkg::*;
#(
    parameter int K_H        = DEF_K_H,
    parameter int K_W        = DEF_K_W,
    parameter int DATA_WIDTH = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int PROD_W     = DEF_PROD_W
) (
    input  logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0] win,
    input  logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0] wgt,
    input  logic signed [ACC_W-1:0]                 bias,
    input  logic                                    relu_en,
    output logic signed [ACC_W-1:0]                 result
);
    logic signed [PROD_W-1:0] pix_s;
    logic signed [PROD_W-1:0] wgt_s;
    logic signed [PROD_W-1:0] prod;
    logic signed [ACC_W-1:0]  acc;

    // Sum of sign-extended products on top of the bias, ReLU applied last
    always_comb begin
        pix_s = '0;
        wgt_s = '0;
        prod  = '0;
        acc   = bias;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
                pix_s = {{(PROD_W-DATA_WIDTH){1'b0}}, win[r][c]};
                wgt_s = {{(PROD_W-DATA_WIDTH){wgt[r][c][DATA_WIDTH-1]}}, wgt[r][c]};
                prod  = pix_s * wgt_s;
                acc   = acc + {{(ACC_W-PROD_W){prod[PROD_W-1]}}, prod};
            end
        end
        result = (relu_en && acc[ACC_W-1]) ? '0 : acc;
    end

endmodule

// File: rtl/conv_stream_engine.sv
// conv_stream_engine: slides a K_H x K_W window over a stationary image with
// stride 1/2, streams one result pixel per cycle over valid/ready.
// Optional feature macro: CONV_PAD_EN adds the pad input (1-pixel zero border).
//
// state   | meaning
// S_IDLE  | waiting for start; geometry checked when start arrives
// S_RUN   | issuing one window per cycle whenever the pipeline can advance
// S_DRAIN | all windows issued, waiting for MAC and output registers to empty
// S_DONE  | one-cycle done pulse, then back to idle
module conv_stream_engine
    import conv_pkg::*;
#(
    parameter int K_H        = DEF_K_H,
    parameter int K_W        = DEF_K_W,
    parameter int MAX_H      = 16,
    parameter int MAX_W      = 15,
    parameter int DATA_WIDTH = DEF_DATA_W,
    parameter int ACC_W      = DEF_ACC_W,
    parameter int ADDR_W     = 8
) (
    input  logic                                        clk,
    input  logic                                        rst_n,
    input  logic                                        start,
    input  logic [4:0]                                  in_h,
    input  logic [4:0]                                  in_w,
    input  logic                                        stride2,
    input  logic                                        relu_en,
    input  logic signed [ACC_W-1:0]                     bias,
`ifdef CONV_PAD_EN
    input  logic                                        pad,
`endif
    input  logic [MAX_H-1:0][MAX_W-1:0][DATA_WIDTH-1:0] in_img,
    // Weight elements are two's complement; treated as signed inside conv_mac
    input  logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0]     w_conv,
    input  logic                                        out_ready,
    output logic                                        out_valid,
    output logic signed [ACC_W-1:0]                     out_pixel,
    output logic [ADDR_W-1:0]                           out_addr,
    output logic                                        busy,
    output logic                                        done,
    output logic                                        cfg_err
);
    localparam int RW = (MAX_H > 1) ? $clog2(MAX_H) : 1;
    localparam int CW = (MAX_W > 1) ? $clog2(MAX_W) : 1;

    state_t                  state_q, state_d;
    logic [4:0]              out_h_q, out_h_d, out_w_q, out_w_d;
    logic [4:0]              oy_q, oy_d, ox_q, ox_d;
    logic                    stride_q, stride_d, relu_q, relu_d;
    logic signed [ACC_W-1:0] bias_q, bias_d;
    logic [ADDR_W-1:0]       addr_q, addr_d;
    logic                    s1_valid_q, s1_valid_d;
    logic signed [ACC_W-1:0] s1_pixel_q, s1_pixel_d;
    logic [ADDR_W-1:0]       s1_addr_q, s1_addr_d;
    logic                    out_valid_q, out_valid_d;
    logic signed [ACC_W-1:0] out_pixel_q, out_pixel_d;
    logic [ADDR_W-1:0]       out_addr_q, out_addr_d;
    logic                    cfg_err_q, cfg_err_d;
`ifdef CONV_PAD_EN
    logic                    pad_q, pad_d;
    logic [4:0]              in_h_q, in_h_d, in_w_q, in_w_d;
`endif

    logic [K_H-1:0][K_W-1:0][DATA_WIDTH-1:0] win;
    logic signed [ACC_W-1:0] mac_out;
    logic                    adv1, adv2, issue, last_win, geom_ok;
    int                      eff_h, eff_w;

    // Effective (padded) geometry of the requested pass and its legality
    always_comb begin
`ifdef CONV_PAD_EN
        eff_h = int'(in_h) + (pad ? 2 : 0);
        eff_w = int'(in_w) + (pad ? 2 : 0);
`else
        eff_h = int'(in_h);
        eff_w = int'(in_w);
`endif
        geom_ok = (eff_h >= K_H) && (eff_w >= K_W) &&
                  (int'(in_h) <= MAX_H) && (int'(in_w) <= MAX_W);
    end

    // Gather the window at (oy, ox); taps on the zero border read 0
    always_comb begin
        int row, col, step;
        win  = '0;
        row  = 0;
        col  = 0;
        step = stride_q ? 2 : 1;
        for (int r = 0; r < K_H; r++) begin
            for (int c = 0; c < K_W; c++) begin
`ifdef CONV_PAD_EN
                row = int'(oy_q) * step + r - (pad_q ? 1 : 0);
                col = int'(ox_q) * step + c - (pad_q ? 1 : 0);
                if (row >= 0 && row < int'(in_h_q) && col >= 0 && col < int'(in_w_q))
                    win[r][c] = in_img[row[RW-1:0]][col[CW-1:0]];
`else
                row = int'(oy_q) * step + r;
                col = int'(ox_q) * step + c;
                win[r][c] = in_img[row[RW-1:0]][col[CW-1:0]];
`endif
            end
        end
    end

    conv_mac #(
        .K_H        (K_H),
        .K_W        (K_W),
        .DATA_WIDTH (DATA_WIDTH),
        .ACC_W      (ACC_W),
        .PROD_W     (prod_width(DATA_WIDTH))
    ) u_mac (
        .win     (win),
        .wgt     (w_conv),
        .bias    (bias_q),
        .relu_en (relu_q),
        .result  (mac_out)
    );

    // FSM, window counters and the two-stage pipeline with back-propagating stall
    always_comb begin
        state_d     = state_q;
        out_h_d     = out_h_q;
        out_w_d     = out_w_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        stride_d    = stride_q;
        relu_d      = relu_q;
        bias_d      = bias_q;
        addr_d      = addr_q;
        s1_valid_d  = s1_valid_q;
        s1_pixel_d  = s1_pixel_q;
        s1_addr_d   = s1_addr_q;
        out_valid_d = out_valid_q;
        out_pixel_d = out_pixel_q;
        out_addr_d  = out_addr_q;
        cfg_err_d   = 1'b0;
`ifdef CONV_PAD_EN
        pad_d       = pad_q;
        in_h_d      = in_h_q;
        in_w_d      = in_w_q;
`endif
        adv2     = !out_valid_q || out_ready;
        adv1     = !s1_valid_q || adv2;
        issue    = (state_q == S_RUN) && adv1;
        last_win = (ox_q == out_w_q - 5'd1) && (oy_q == out_h_q - 5'd1);

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (geom_ok) begin
                        out_h_d  = 5'(out_dim(eff_h, K_H, stride2));
                        out_w_d  = 5'(out_dim(eff_w, K_W, stride2));
                        stride_d = stride2;
                        relu_d   = relu_en;
                        bias_d   = bias;
                        oy_d     = '0;
                        ox_d     = '0;
                        addr_d   = '0;
`ifdef CONV_PAD_EN
                        pad_d    = pad;
                        in_h_d   = in_h;
                        in_w_d   = in_w;
`endif
                        state_d  = S_RUN;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (issue) begin
                    addr_d = addr_q + ADDR_W'(1);
                    if (last_win) begin
                        state_d = S_DRAIN;
                    end else if (ox_q == out_w_q - 5'd1) begin
                        ox_d = '0;
                        oy_d = oy_q + 5'd1;
                    end else begin
                        ox_d = ox_q + 5'd1;
                    end
                end
            end
            S_DRAIN: begin
                if (!s1_valid_q && !out_valid_q)
                    state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase

        if (adv1) begin
            s1_valid_d = issue;
            s1_pixel_d = mac_out;
            s1_addr_d  = addr_q;
        end
        if (adv2) begin
            out_valid_d = s1_valid_q;
            out_pixel_d = s1_pixel_q;
            out_addr_d  = s1_addr_q;
        end
    end

    // State registers; reset aborts any pass immediately
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_h_q     <= '0;
            out_w_q     <= '0;
            oy_q        <= '0;
            ox_q        <= '0;
            stride_q    <= 1'b0;
            relu_q      <= 1'b0;
            bias_q      <= '0;
            addr_q      <= '0;
            s1_valid_q  <= 1'b0;
            s1_pixel_q  <= '0;
            s1_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_pixel_q <= '0;
            out_addr_q  <= '0;
            cfg_err_q   <= 1'b0;
`ifdef CONV_PAD_EN
            pad_q       <= 1'b0;
            in_h_q      <= '0;
            in_w_q      <= '0;
`endif
        end else begin
            state_q     <= state_d;
            out_h_q     <= out_h_d;
            out_w_q     <= out_w_d;
            oy_q        <= oy_d;
            ox_q        <= ox_d;
            stride_q    <= stride_d;
            relu_q      <= relu_d;
            bias_q      <= bias_d;
            addr_q      <= addr_d;
            s1_valid_q  <= s1_valid_d;
            s1_pixel_q  <= s1_pixel_d;
            s1_addr_q   <= s1_addr_d;
            out_valid_q <= out_valid_d;
            out_pixel_q <= out_pixel_d;
            out_addr_q  <= out_addr_d;
            cfg_err_q   <= cfg_err_d;
`ifdef CONV_PAD_EN
            pad_q       <= pad_d;
            in_h_q      <= in_h_d;
            in_w_q      <= in_w_d;
`endif
        end
    end

    assign out_valid = out_valid_q;
    assign out_pixel = out_pixel_q;
    assign out_addr  = out_addr_q;
    assign cfg_err   = cfg_err_q;
    assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done      = (state_q == S_DONE);

endmodule

// File: tb/tb_conv_stream_engine.sv
// Scoreboard bench for conv_stream_engine: a plain-arithmetic convolution model
// queues expected pixels; a negedge monitor pops and compares on each handshake.
module tb_conv_stream_engine;
    localparam int KH  = 3;
    localparam int KW  = 3;
    localparam int MH  = 16;
    localparam int MW  = 15;
    localparam int DW  = 8;
    localparam int AW  = 24;
    localparam int ADW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic stride2 = 1'b0;
    logic relu_en = 1'b0;
    logic out_ready = 1'b1;
    logic [4:0] in_h = '0;
    logic [4:0] in_w = '0;
    logic signed [AW-1:0] bias = '0;
    logic [MH-1:0][MW-1:0][DW-1:0] in_img = '0;
    logic [KH-1:0][KW-1:0][DW-1:0] w_conv = '0;
`ifdef CONV_PAD_EN
    logic pad = 1'b0;
`endif
    logic out_valid, busy, done, cfg_err;
    logic signed [AW-1:0] out_pixel;
    logic [ADW-1:0] out_addr;

    typedef struct {
        int pix;
        int addr;
    } exp_t;

    int   img [MH][MW];
    int   wts [KH][KW];
    exp_t exp_q[$];
    exp_t e;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt = 0;
    bit   rnd_ready = 1'b0;
    bit   stall_seen = 1'b0;
    int   stall_pix, stall_addr;

    conv_stream_engine dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .in_h      (in_h),
        .in_w      (in_w),
        .stride2   (stride2),
        .relu_en   (relu_en),
        .bias      (bias),
`ifdef CONV_PAD_EN
        .pad       (pad),
`endif
        .in_img    (in_img),
        .w_conv    (w_conv),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_pixel (out_pixel),
        .out_addr  (out_addr),
        .busy      (busy),
        .done      (done),
        .cfg_err   (cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d", name, act, req);
        end
    endtask

    task automatic fill(input int pix, input int wt);
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++)
                img[r][c] = pix;
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KW; c++)
                wts[r][c] = wt;
    endtask

    task automatic load_arrays();
        for (int r = 0; r < MH; r++)
            for (int c = 0; c < MW; c++)
                in_img[r][c] = DW'(img[r][c]);
        for (int r = 0; r < KH; r++)
            for (int c = 0; c < KW; c++)
                w_conv[r][c] = DW'(wts[r][c]);
    endtask

    // Reference convolution: valid windows only, row-major output order
    task automatic model(input int h, input int w, input int s, input int relu, input int b);
        int oh, ow, acc;
        exp_t x;
        oh = (h - KH) / s + 1;
        ow = (w - KW) / s + 1;
        for (int oy = 0; oy < oh; oy++) begin
            for (int ox = 0; ox < ow; ox++) begin
                acc = b;
                for (int r = 0; r < KH; r++)
                    for (int c = 0; c < KW; c++)
                        acc += img[oy*s + r][ox*s + c] * wts[r][c];
                if (relu != 0 && acc < 0)
                    acc = 0;
                x.pix  = acc;
                x.addr = oy * ow + ox;
                exp_q.push_back(x);
            end
        end
    endtask

    // Random backpressure when enabled
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Monitor: handshake compare, stall stability, done pulse counting
    always @(negedge clk) begin
        if (!rst_n) begin
            stall_seen = 1'b0;
        end else begin
            if (done) begin
                done_cnt++;
                chk("busy_low_at_done", int'(busy), 0);
            end
            if (stall_seen) begin
                chk("stall_valid_held", int'(out_valid), 1);
                chk("stall_pixel_stable", int'(out_pixel), stall_pix);
                chk("stall_addr_stable", int'(out_addr), stall_addr);
                stall_seen = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: actual pixel %0d addr %0d, required no output",
                             int'(out_pixel), int'(out_addr));
                end else begin
                    e = exp_q.pop_front();
                    chk("out_pixel", int'(out_pixel), e.pix);
                    chk("out_addr", int'(out_addr), e.addr);
                end
            end else if (out_valid) begin
                stall_seen = 1'b1;
                stall_pix  = int'(out_pixel);
                stall_addr = int'(out_addr);
            end
        end
    end

    task automatic run_pass(input string tag, input int h, input int w, input int s,
                            input int relu, input int b, input bit rr, input bit poke);
        int d0, n;
        rnd_ready = rr;
        load_arrays();
        model(h, w, s, relu, b);
        d0 = done_cnt;
        @(posedge clk);
        #1;
        in_h    = 5'(h);
        in_w    = 5'(w);
        stride2 = (s == 2);
        relu_en = (relu != 0);
        bias    = AW'(b);
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_after_start"}, int'(busy), 1);
        @(posedge clk);
        #1;
        chk({tag, "_no_valid_at_1"}, int'(out_valid), 0);
        @(posedge clk);
        #1;
        chk({tag, "_valid_at_2"}, int'(out_valid), 1);
        if (poke) begin
            in_h  = 5'd2;
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
            chk({tag, "_start_busy_ignored"}, int'(busy), 1);
            chk({tag, "_no_cfg_err_busy"}, int'(cfg_err), 0);
            in_h = 5'(h);
        end
        n = 0;
        while (done_cnt == d0 && n < 4000) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (done_cnt == d0) begin
            checks++;
            errors++;
            $display("FAIL %s_done_timeout: actual no done after %0d cycles, required done", tag, n);
        end
        repeat (3) @(posedge clk);
        #1;
        chk({tag, "_done_once"}, done_cnt - d0, 1);
        chk({tag, "_all_pixels_seen"}, exp_q.size(), 0);
        chk({tag, "_idle_after"}, int'(busy), 0);
        exp_q.delete();
        rnd_ready = 1'b0;
    endtask

    task automatic cfg_reject(input string tag, input int h, input int w);
        @(posedge clk);
        #1;
        in_h    = 5'(h);
        in_w    = 5'(w);
        stride2 = 1'b0;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_cfg_err"}, int'(cfg_err), 1);
        chk({tag, "_busy_low"}, int'(busy), 0);
        @(posedge clk);
        #1;
        chk({tag, "_cfg_err_one_cycle"}, int'(cfg_err), 0);
        chk({tag, "_still_idle"}, int'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: actual simulation still running, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int d0, h, w, s, relu, b;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_cfg_err", int'(cfg_err), 0);
        chk("rst_out_pixel", int'(out_pixel), 0);
        chk("rst_out_addr", int'(out_addr), 0);
        rst_n = 1'b1;

        fill(1, 1);
        run_pass("t1", 6, 6, 1, 0, 0, 1'b0, 1'b1);
        run_pass("t2", 6, 6, 2, 1, -10, 1'b0, 1'b0);
        fill(255, -1);
        run_pass("t3", 4, 4, 1, 0, 0, 1'b0, 1'b0);
        fill(1, 1);
        run_pass("t4", 6, 6, 1, 0, 0, 1'b1, 1'b0);

        cfg_reject("t5_h2", 2, 6);
        cfg_reject("t5_w16", 6, 16);
        cfg_reject("t5_h17", 17, 6);

        // Reset in the middle of a pass
        d0 = done_cnt;
        load_arrays();
        model(6, 6, 1, 0, 0);
        @(posedge clk);
        #1;
        in_h = 5'd6; in_w = 5'd6; stride2 = 1'b0; relu_en = 1'b0; bias = '0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_out_valid", int'(out_valid), 0);
        chk("t6_rst_busy", int'(busy), 0);
        chk("t6_rst_out_pixel", int'(out_pixel), 0);
        chk("t6_rst_out_addr", int'(out_addr), 0);
        chk("t6_rst_done", int'(done), 0);
        exp_q.delete();
        repeat (2) @(posedge clk);
        #3;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("t6_no_done_after_abort", done_cnt - d0, 0);
        run_pass("t6", 6, 6, 1, 0, 0, 1'b0, 1'b0);

        for (int k = 0; k < 4; k++) begin
            for (int r = 0; r < MH; r++)
                for (int c = 0; c < MW; c++)
                    img[r][c] = int'($urandom_range(0, 255));
            for (int r = 0; r < KH; r++)
                for (int c = 0; c < KW; c++)
                    wts[r][c] = int'($urandom_range(0, 255)) - 128;
            h    = int'($urandom_range(3, 16));
            w    = int'($urandom_range(3, 15));
            s    = int'($urandom_range(1, 2));
            relu = int'($urandom_range(0, 1));
            b    = int'($urandom_range(0, 4000)) - 2000;
            run_pass("rnd", h, w, s, relu, b, 1'b1, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
